pipe_stage_reg: RTL

//  Parametrised pipeline stage register. Generalises the fixed inter-stage latches
//  (IF/ID .. MEM/WB) to any payload width and adds a valid/ready handshake, flush,
//  and an optional 2-entry skid buffer so back-pressure never forms a combinational path.

---
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional second (skid) entry that keeps out_ready off the in_ready path.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | one entry in r_main, presented downstream
// ST_TWO   | r_main presented, r_skid queued behind it (SKID=1 only), in_ready=0
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 20,
    parameter bit               SKID      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic [1:0]       r_occ;
    logic             r_in_ready;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    // Without the skid entry the stage can only accept when its single slot drains this cycle.
    assign w_in_ready = SKID ? r_in_ready : (out_ready | ~r_out_valid);
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_main;
    assign occupancy  = r_occ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= RESET_VAL;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            // Payload registers keep their last value; they are ignored while out_valid=0.
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main      <= in_data;
                    end else if (SKID && w_in_fire) begin
                        r_state     <= ST_TWO;
                        r_skid      <= in_data;
                        r_occ       <= 2'd2;
                        r_in_ready  <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_state     <= ST_ONE;
                        r_main      <= r_skid;
                        r_occ       <= 2'd1;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_occ       <= 2'd0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
